// File: rtl/prio_enc_arb.sv
// Registered priority encoder / arbiter: sticky pending capture, one index at a
// time under a valid/ack handshake, fixed-priority or round-robin selection.
module prio_enc_arb #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic             rr_mode,
  input  logic             ack,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     pend
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     r_pend;

  logic             w_ack_fire;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_cand;
  logic             w_any;
  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W-1:0] w_scan_base;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_rr_off;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_rr_sel;
  logic [IDX_W-1:0] w_fix_sel;
  logic [IDX_W-1:0] w_sel;

  assign w_ack_fire = (r_state == S_GRANT) && ack;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clr
      assign w_clr[gi] = w_ack_fire && (r_idx == IDX_W'(gi));
    end
  endgenerate

  // New requests are OR-ed in after the clear, so a re-request on the ack cycle survives.
  assign w_cand = (r_pend & ~w_clr) | req_in;
  assign w_any  = |w_cand;

  assign w_ptr_next  = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + IDX_W'(1);
  assign w_scan_base = w_ack_fire ? w_ptr_next : r_ptr;

  // Rotate the candidates so the scan start lands at bit 0, then take the lowest set bit.
  assign w_dbl = {w_cand, w_cand};
  assign w_rot = N'(w_dbl >> w_scan_base);

  always_comb begin
    w_rr_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_rr_off = IDX_W'(i);
    end
  end

  assign w_sum    = {1'b0, w_scan_base} + {1'b0, w_rr_off};
  assign w_rr_sel = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N)) : IDX_W'(w_sum);

  always_comb begin
    w_fix_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) w_fix_sel = IDX_W'(i);
    end
  end

  assign w_sel = rr_mode ? w_rr_sel : w_fix_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_pend  <= '0;
    end else begin
      r_pend <= w_cand;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_sel;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (ack) begin
            r_ptr <= w_ptr_next;
            if (w_any) begin
              r_idx <= w_sel;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid = (r_state == S_GRANT);
  assign idx   = r_idx;
  assign pend  = r_pend;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Bench for prio_enc_arb at N = 8, 4 and 5: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural arbiter model.
module tb_prio_enc_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int         cur = 0;
  logic [7:0] tb_req = '0;
  logic       tb_ack = 1'b0;
  logic       tb_rr  = 1'b0;

  logic [7:0] req8;
  logic [3:0] req4;
  logic [4:0] req5;
  logic       v8, v4, v5;
  logic [2:0] i8;
  logic [1:0] i4;
  logic [2:0] i5;
  logic [7:0] p8;
  logic [3:0] p4;
  logic [4:0] p5;

  assign req8 = (cur == 0) ? tb_req : 8'h00;
  assign req4 = (cur == 1) ? tb_req[3:0] : 4'h0;
  assign req5 = (cur == 2) ? tb_req[4:0] : 5'h00;

  prio_enc_arb #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .req_in(req8), .rr_mode(tb_rr),
    .ack(tb_ack && cur == 0), .valid(v8), .idx(i8), .pend(p8)
  );
  prio_enc_arb #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_in(req4), .rr_mode(tb_rr),
    .ack(tb_ack && cur == 1), .valid(v4), .idx(i4), .pend(p4)
  );
  prio_enc_arb #(.N(5)) u_dut5 (
    .clk(clk), .rst(rst), .req_in(req5), .rr_mode(tb_rr),
    .ack(tb_ack && cur == 2), .valid(v5), .idx(i5), .pend(p5)
  );

  int obs_valid, obs_idx, obs_pend;
  always_comb begin
    obs_valid = 0;
    obs_idx   = 0;
    obs_pend  = 0;
    case (cur)
      0: begin obs_valid = int'(v8); obs_idx = int'(i8); obs_pend = int'(p8); end
      1: begin obs_valid = int'(v4); obs_idx = int'(i4); obs_pend = int'(p4); end
      default: begin obs_valid = int'(v5); obs_idx = int'(i5); obs_pend = int'(p5); end
    endcase
  end

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Behavioural model: arbiter state as plain integers.
  int mn = 8;
  int m_pend, m_valid, m_idx, m_ptr;

  function automatic int pick(input int cand, input int ptr, input bit rr, input int n);
    if (rr) begin
      for (int k = 0; k < n; k++)
        if (cand[(ptr + k) % n]) return (ptr + k) % n;
    end else begin
      for (int i = n - 1; i >= 0; i--)
        if (cand[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_valid = 0; m_idx = 0; m_ptr = 0;
  endtask

  task automatic model_step(input int r, input bit a, input bit m);
    int clr, pn;
    clr = (m_valid != 0 && a) ? (1 << m_idx) : 0;
    pn  = ((m_pend & ~clr) | r) & ((1 << mn) - 1);
    if (m_valid == 0) begin
      if (pn != 0) begin
        m_idx   = pick(pn, m_ptr, m, mn);
        m_valid = 1;
      end
    end else if (a) begin
      m_ptr = (m_idx + 1) % mn;
      if (pn != 0) m_idx = pick(pn, m_ptr, m, mn);
      else         m_valid = 0;
    end
    m_pend = pn;
  endtask

  task automatic compare_model();
    check("valid", obs_valid, m_valid);
    check("pend", obs_pend, m_pend);
    if (m_valid != 0) begin
      check("idx", obs_idx, m_idx);
      check("idx_range", int'(obs_idx < mn), 1);
    end
  endtask

  // One clock: drive, edge, advance model, compare 1 ns after the edge.
  task automatic cyc(input logic [7:0] r, input logic a, input logic m);
    tb_req = r; tb_ack = a; tb_rr = m;
    @(posedge clk);
    model_step(int'(r), a, m);
    #1;
    ncyc++;
    $display("cyc %0d n=%0d req=%h ack=%0d rr=%0d -> valid=%0d idx=%0d pend=%h",
             ncyc, mn, r, a, m, obs_valid, obs_idx, obs_pend);
    compare_model();
  endtask

  task automatic do_reset();
    tb_req = '0; tb_ack = 1'b0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic select(input int which, input int n);
    @(posedge clk); #1;
    cur = which;
    mn  = n;
    do_reset();
  endtask

  task automatic random_phase(input int cycles);
    logic [7:0] r;
    logic       a, m;
    for (int c = 0; c < cycles; c++) begin
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      a = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 7) == 0) ? ~tb_rr : tb_rr;
      cyc(r, a, m);
    end
  endtask

  initial begin
    model_reset();
    // ---------------- N = 8 ----------------
    select(0, 8);
    check("reset_valid", obs_valid, 0);
    check("reset_idx", obs_idx, 0);
    check("reset_pend", obs_pend, 0);

    // Async reset mid-grant with pend = A5.
    cyc(8'hA5, 1'b0, 1'b0);
    check("pre_rst_pend", obs_pend, 'hA5);
    check("pre_rst_idx", obs_idx, 7);
    rst = 1'b1;
    #1;
    check("async_rst_valid", obs_valid, 0);
    check("async_rst_idx", obs_idx, 0);
    check("async_rst_pend", obs_pend, 0);
    #1;
    rst = 1'b0;
    model_reset();

    // Fixed priority, back-to-back with ack held.
    cyc(8'b0000_1010, 1'b1, 1'b0);
    check("fix_first", obs_idx, 3);
    cyc(8'h00, 1'b1, 1'b0);
    check("fix_b2b", obs_idx, 1);
    check("fix_b2b_valid", obs_valid, 1);
    cyc(8'h00, 1'b1, 1'b0);
    check("fix_drain_valid", obs_valid, 0);
    check("fix_drain_pend", obs_pend, 0);

    // No pre-emption while ack is low.
    do_reset();
    cyc(8'h04, 1'b0, 1'b0);
    check("hold_grant", obs_idx, 2);
    cyc(8'h80, 1'b0, 1'b0);
    check("hold_idx", obs_idx, 2);
    check("hold_pend", obs_pend, 'h84);
    cyc(8'h00, 1'b1, 1'b0);
    check("hold_next", obs_idx, 7);
    cyc(8'h00, 1'b1, 1'b0);

    // Round-robin over all lines, then a wrap from ptr = 6.
    do_reset();
    cyc(8'hFF, 1'b1, 1'b1);
    check("rr_seq0", obs_idx, 0);
    for (int k = 1; k < 8; k++) begin
      cyc(8'h00, 1'b1, 1'b1);
      check("rr_seq", obs_idx, k);
    end
    cyc(8'h00, 1'b1, 1'b1);
    check("rr_done_valid", obs_valid, 0);
    cyc(8'h20, 1'b0, 1'b1);
    check("rr_g5", obs_idx, 5);
    cyc(8'h00, 1'b1, 1'b1);
    check("rr_g5_done", obs_valid, 0);
    cyc(8'b0100_0001, 1'b1, 1'b1);
    check("rr_wrap_a", obs_idx, 6);
    cyc(8'h00, 1'b1, 1'b1);
    check("rr_wrap_b", obs_idx, 0);
    cyc(8'h00, 1'b1, 1'b1);

    // Set wins over clear on the ack cycle.
    do_reset();
    cyc(8'h20, 1'b0, 1'b0);
    check("sw_grant", obs_idx, 5);
    cyc(8'h20, 1'b1, 1'b0);
    check("sw_pend5", (obs_pend >> 5) & 1, 1);
    check("sw_regrant", obs_idx, 5);
    check("sw_valid", obs_valid, 1);
    cyc(8'h00, 1'b1, 1'b0);

    // Ack with nothing granted changes nothing.
    do_reset();
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h02, 1'b0, 1'b1);
    check("idle_ack_ptr", obs_idx, 1);

    do_reset();
    random_phase(400);

    // ---------------- N = 4 ----------------
    select(1, 4);
    for (int b = 0; b < 4; b++) begin
      cyc(8'(1 << b), 1'b0, 1'b0);
      check("n4_single", obs_idx, b);
      cyc(8'h00, 1'b1, 1'b0);
    end
    cyc(8'h0F, 1'b1, 1'b0);
    check("n4_fix_top", obs_idx, 3);
    for (int k = 0; k < 3; k++) cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    do_reset();
    random_phase(300);

    // ---------------- N = 5 ----------------
    select(2, 5);
    for (int b = 0; b < 5; b++) begin
      cyc(8'(1 << b), 1'b0, 1'b0);
      check("n5_single", obs_idx, b);
      cyc(8'h00, 1'b1, 1'b0);
    end
    do_reset();
    cyc(8'h1F, 1'b1, 1'b1);
    check("n5_rr0", obs_idx, 0);
    for (int k = 1; k < 5; k++) begin
      cyc(8'h00, 1'b1, 1'b1);
      check("n5_rr", obs_idx, k);
    end
    cyc(8'h1F, 1'b1, 1'b1);
    check("n5_rr_wrap", obs_idx, 0);
    for (int k = 0; k < 5; k++) cyc(8'h00, 1'b1, 1'b1);
    check("n5_rr_idle", obs_valid, 0);
    do_reset();
    random_phase(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
